pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
Parametrised program-counter unit for the ExceptioNull CPU family. It is the successor to the fixed 8-bit program counter.
- Generalised in PC width and offset width.
- Adds a hardware return-address stack (call/return) with depth tracking, sticky overflow/underflow flags and a stall input.
- Sits between control_unit (which drives pc_ctrl) and instruction_mem (which consumes pc).

Parameters:
PC_W, 8, program counter width in bits
OFF_W, 8, signed relative-branch offset width (OFF_W <= PC_W)
STACK_DEPTH, 4, return-address stack entries (power of two, >= 2)
RESET_VEC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  advance enable; 0 = stall, no state change
pc_ctrl  in  3  operation: 0 NEXT, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5-7 HOLD
branch_taken  in  1  qualifies BRANCH
offset  in  OFF_W  signed relative offset for BRANCH
target  in  PC_W  absolute target for JUMP/CALL
err_clr  in  1  clears sticky error flags
pc  out  PC_W  current program counter (registered)
depth  out  $clog2(STACK_DEPTH)+1  number of valid stack entries
full  out  1  depth == STACK_DEPTH (combinational from depth)
empty  out  1  depth == 0 (combinational from depth)
overflow  out  1  sticky: CALL attempted while full
underflow  out  1  sticky: RET attempted while empty

Behaviour:
- Reset (async, any time, including mid-operation) forces:
  - pc = RESET_VEC, depth = 0, overflow = 0, underflow = 0.
  - Stack contents are don't-care.
- All updates occur on the rising clk edge; pc changes one cycle after the operation is presented. No combinational path from inputs to pc.
- en = 0: pc, depth and stack are held. err_clr still acts.
- en = 1, per pc_ctrl:
  - NEXT: pc <= pc + 1, mod 2^PC_W (wraps from all-ones to 0).
  - BRANCH: if branch_taken, pc <= pc + sign_extend(offset) mod 2^PC_W; otherwise pc <= pc + 1.
  - JUMP: pc <= target.
  - CALL, not full: stack[depth] <= pc + 1 (wrapped), depth += 1, pc <= target.
  - CALL, full: no push, depth unchanged, pc <= pc + 1, overflow <= 1.
  - RET, not empty: pc <= stack[depth-1], depth -= 1.
  - RET, empty: pc <= pc + 1, underflow <= 1.
  - HOLD (5-7): pc unchanged. Reserved encodings are legal and are not errors.
- Sticky flags:
  - Once set, a flag remains set until err_clr = 1 or reset.
  - If err_clr and a new error occur in the same cycle, the flag is set (set wins).
- Stack is strict LIFO; only the top entry is observable via RET.
- Arithmetic: offset is sign-extended to PC_W before the add. Carry out is discarded.

Optional Feature:
Macro PCU_CIRCULAR_STACK_EN.
- Defined: CALL while full still pushes. It overwrites the oldest entry (circular buffer; the base pointer advances), depth stays at STACK_DEPTH, pc <= target, and overflow <= 1.
- Undefined: overflow handling is as above (CALL suppressed, pc + 1).
- RET semantics are identical in both builds.

Decomposition:
- Package pcu_pkg holds:
  - pc_ctrl encodings: PC_NEXT, PC_BRANCH, PC_JUMP, PC_CALL, PC_RET, PC_HOLD.
  - Default widths: PC_W_DEF = 8, OFF_W_DEF = 8.
  - control_unit shares these encodings.
- One sub-module, ras_stack (parametrised LIFO):
  - Inputs: push, pop, wdata.
  - Outputs: rdata, depth, full, empty.
  - Implements the circular-overwrite variant under the same macro.
- pc_stack_unit contains the pc register, next-pc mux and sticky flags.

Test Plan:
- Reset, then 3 cycles NEXT with PC_W=8, RESET_VEC=0 -> pc = 0, 1, 2, 3; assert rst async mid-cycle -> pc = 0 immediately, depth = 0.
- pc = 0xFE, NEXT twice -> pc = 0xFF then 0x00 (wrap); BRANCH taken, offset = 0xFC at pc = 0x10 -> pc = 0x0C; BRANCH not taken -> pc = 0x11.
- pc = 0x20, CALL target = 0x80 -> pc = 0x80, depth = 1; RET -> pc = 0x21, depth = 0; en = 0 during CALL -> no change.
- STACK_DEPTH = 4, five nested CALLs -> depth = 4, full = 1, overflow = 1, fifth CALL gives pc = prev + 1 (macro undefined); with PCU_CIRCULAR_STACK_EN, pc = target and the first return address is lost after 4 RETs.
- RET with depth = 0 at pc = 0x40 -> pc = 0x41, underflow = 1; err_clr with no new error -> underflow = 0; err_clr together with another empty RET -> underflow stays 1.
- pc_ctrl = 6 with en = 1 -> pc and depth unchanged, no flags set.

Source files
------------

// File: rtl/pcu_pkg.sv
// pcu_pkg: pc_ctrl encodings and default widths shared by pc_stack_unit and control_unit.
package pcu_pkg;
    localparam int PC_W_DEF  = 8;
    localparam int OFF_W_DEF = 8;
    localparam logic [2:0] PC_NEXT   = 3'd0;
    localparam logic [2:0] PC_BRANCH = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_CALL   = 3'd3;
    localparam logic [2:0] PC_RET    = 3'd4;
    localparam logic [2:0] PC_HOLD   = 3'd5;
endpackage

// File: rtl/pc_stack_unit_ras.sv
// ras_stack: return-address LIFO; with PCU_CIRCULAR_STACK_EN a push while full
// overwrites the oldest entry by advancing the base pointer.
module ras_stack
    import pcu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = PC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_D   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_P = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   depth_q, depth_d;
    logic [AW-1:0] base_q, base_d, wptr, rptr;
    logic          wr;

    // When full the low depth bits are zero, so wptr lands on the oldest slot.
    always_comb begin
        wptr = base_q + depth_q[AW-1:0];
        rptr = wptr - ONE_P;
`ifdef PCU_CIRCULAR_STACK_EN
        wr     = push;
        base_d = (push && full) ? base_q + ONE_P : base_q;
`else
        wr     = push && !full;
        base_d = base_q;
`endif
        depth_d = (push && !full) ? depth_q + ONE_D :
                  (pop && !empty) ? depth_q - ONE_D : depth_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
            base_q  <= '0;
        end else begin
            depth_q <= depth_d;
            base_q  <= base_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr] <= wdata;
    end

    assign rdata = mem_q[rptr];
    assign depth = depth_q;
    assign full  = depth_q == DEPTH_V;
    assign empty = depth_q == '0;
endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with next-pc mux, return-address stack and sticky errors.
// PCU_CIRCULAR_STACK_EN: CALL while full still pushes (oldest entry lost) and jumps.
module pc_stack_unit
    import pcu_pkg::*;
#(
    parameter int              PC_W        = PC_W_DEF,
    parameter int              OFF_W       = OFF_W_DEF,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [2:0]                     pc_ctrl,
    input  logic                           branch_taken,
    input  logic [OFF_W-1:0]               offset,
    input  logic [PC_W-1:0]                target,
    input  logic                           err_clr,
    output logic [PC_W-1:0]                pc,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           full,
    output logic                           empty,
    output logic                           overflow,
    output logic                           underflow
);
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, off_ext, rdata;
    logic overflow_q, overflow_d, underflow_q, underflow_d;
    logic push, pop, ovf_set, unf_set;

    assign pc_inc  = pc_q + PC_W'(1);
    assign off_ext = PC_W'($signed(offset));

    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (en) begin
            case (pc_ctrl)
                PC_NEXT:   pc_d = pc_inc;
                PC_BRANCH: pc_d = branch_taken ? pc_q + off_ext : pc_inc;
                PC_JUMP:   pc_d = target;
                PC_CALL: begin
                    push    = 1'b1;
                    ovf_set = full;
`ifdef PCU_CIRCULAR_STACK_EN
                    pc_d    = target;
`else
                    pc_d    = full ? pc_inc : target;
`endif
                end
                PC_RET: begin
                    pop     = 1'b1;
                    unf_set = empty;
                    pc_d    = empty ? pc_inc : rdata;
                end
                default:   pc_d = pc_q;
            endcase
        end
        overflow_d  = ovf_set | (overflow_q & ~err_clr);
        underflow_d = unf_set | (underflow_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_VEC;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    ras_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (pc_inc),
        .rdata (rdata),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    assign pc        = pc_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: randomized and directed checks of pc_stack_unit against a queue-based model.
module tb_pc_stack_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, branch_taken = 1'b0, err_clr = 1'b0;
    logic [2:0] pc_ctrl = 3'd0;
    logic [7:0] offset = 8'd0, target = 8'd0, pc;
    logic [2:0] depth;
    logic       full, empty, overflow, underflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    logic       m_ov, m_un;

    always #5 clk = ~clk;

    pc_stack_unit #(.PC_W(8), .OFF_W(8), .STACK_DEPTH(4), .RESET_VEC(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .pc_ctrl(pc_ctrl), .branch_taken(branch_taken),
        .offset(offset), .target(target), .err_clr(err_clr), .pc(pc), .depth(depth),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", int'(pc), int'(m_pc));
            chk("depth", int'(depth), m_stk.size());
            chk("full", int'(full), int'(m_stk.size() == 4));
            chk("empty", int'(empty), int'(m_stk.size() == 0));
            chk("overflow", int'(overflow), int'(m_ov));
            chk("underflow", int'(underflow), int'(m_un));
        end
    end

    task automatic model_reset();
        m_pc = 8'h00;
        m_stk.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] inc;
        logic ov_new = 1'b0, un_new = 1'b0;
        inc = m_pc + 8'd1;
        if (en) begin
            if (pc_ctrl == 3'd0) m_pc = inc;
            else if (pc_ctrl == 3'd1) m_pc = branch_taken ? 8'(int'(m_pc) + int'($signed(offset))) : inc;
            else if (pc_ctrl == 3'd2) m_pc = target;
            else if (pc_ctrl == 3'd3) begin
                if (m_stk.size() < 4) begin
                    m_stk.push_back(inc);
                    m_pc = target;
                end else begin
                    ov_new = 1'b1;
`ifdef PCU_CIRCULAR_STACK_EN
                    void'(m_stk.pop_front());
                    m_stk.push_back(inc);
                    m_pc = target;
`else
                    m_pc = inc;
`endif
                end
            end else if (pc_ctrl == 3'd4) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin
                    un_new = 1'b1;
                    m_pc = inc;
                end
            end
        end
        m_ov = ov_new | (m_ov & ~err_clr);
        m_un = un_new | (m_un & ~err_clr);
    endtask

    task automatic op(input logic e, input logic [2:0] c, input logic t,
                      input logic [7:0] o, input logic [7:0] tg, input logic clr);
        en = e; pc_ctrl = c; branch_taken = t; offset = o; target = tg; err_clr = clr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic mid_reset();
        en = 1'b0;
        err_clr = 1'b0;
        #3;
        rst = 1'b1;
        model_reset();
        #2;
        chk("async_rst_pc", int'(pc), 0);
        chk("async_rst_depth", int'(depth), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        chk("rst_pc", int'(pc), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_flags", int'({overflow, underflow}), 0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        op(1, 3'd0, 0, 0, 0, 0); chk("next1", int'(pc), 8'h01);
        op(1, 3'd0, 0, 0, 0, 0); chk("next2", int'(pc), 8'h02);
        op(1, 3'd0, 0, 0, 0, 0); chk("next3", int'(pc), 8'h03);
        op(1, 3'd3, 0, 0, 8'h50, 0); chk("call_depth", int'(depth), 1);
        mid_reset();
        op(1, 3'd2, 0, 0, 8'hFE, 0);
        op(1, 3'd0, 0, 0, 0, 0); chk("wrap_ff", int'(pc), 8'hFF);
        op(1, 3'd0, 0, 0, 0, 0); chk("wrap_00", int'(pc), 8'h00);
        op(1, 3'd2, 0, 0, 8'h10, 0);
        op(1, 3'd1, 1, 8'hFC, 0, 0); chk("br_taken", int'(pc), 8'h0C);
        op(1, 3'd2, 0, 0, 8'h10, 0);
        op(1, 3'd1, 0, 8'hFC, 0, 0); chk("br_not_taken", int'(pc), 8'h11);
        op(1, 3'd2, 0, 0, 8'h20, 0);
        op(0, 3'd3, 0, 0, 8'h80, 0); chk("stall_pc", int'(pc), 8'h20);
        chk("stall_depth", int'(depth), 0);
        op(1, 3'd3, 0, 0, 8'h80, 0); chk("call_pc", int'(pc), 8'h80);
        chk("call_d1", int'(depth), 1);
        op(1, 3'd4, 0, 0, 0, 0); chk("ret_pc", int'(pc), 8'h21);
        chk("ret_d0", int'(depth), 0);
        for (int i = 0; i < 4; i++) op(1, 3'd3, 0, 0, 8'h90 + 8'(i), 0);
        chk("nest_full", int'(full), 1);
        op(1, 3'd3, 0, 0, 8'hA0, 0);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_depth", int'(depth), 4);
`ifdef PCU_CIRCULAR_STACK_EN
        chk("ovf_pc", int'(pc), 8'hA0);
        op(1, 3'd4, 0, 0, 0, 0); chk("unwind1", int'(pc), 8'h94);
        op(1, 3'd4, 0, 0, 0, 0); chk("unwind2", int'(pc), 8'h93);
        op(1, 3'd4, 0, 0, 0, 0); chk("unwind3", int'(pc), 8'h92);
        op(1, 3'd4, 0, 0, 0, 0); chk("unwind4", int'(pc), 8'h91);
`else
        chk("ovf_pc", int'(pc), 8'h94);
        op(1, 3'd4, 0, 0, 0, 0); chk("unwind1", int'(pc), 8'h93);
        op(1, 3'd4, 0, 0, 0, 0); chk("unwind2", int'(pc), 8'h92);
        op(1, 3'd4, 0, 0, 0, 0); chk("unwind3", int'(pc), 8'h91);
        op(1, 3'd4, 0, 0, 0, 0); chk("unwind4", int'(pc), 8'h22);
`endif
        chk("unwind_empty", int'(empty), 1);
        op(1, 3'd2, 0, 0, 8'h40, 0);
        op(1, 3'd4, 0, 0, 0, 0); chk("unf_pc", int'(pc), 8'h41);
        chk("unf_flag", int'(underflow), 1);
        op(1, 3'd5, 0, 0, 0, 1); chk("clr_unf", int'(underflow), 0);
        chk("clr_ovf", int'(overflow), 0);
        op(1, 3'd4, 0, 0, 0, 1); chk("set_wins", int'(underflow), 1);
        op(1, 3'd6, 0, 0, 8'h77, 0); chk("hold_pc", int'(pc), 8'h42);
        chk("hold_depth", int'(depth), 0);
        chk("hold_ovf", int'(overflow), 0);
        for (int i = 0; i < 2000; i++) begin
            int r;
            logic [2:0] c;
            r = $urandom_range(0, 9);
            c = (r < 2) ? 3'd0 : (r == 2) ? 3'd1 : (r == 3) ? 3'd2 : (r < 6) ? 3'd3 :
                (r < 8) ? 3'd4 : (r == 8) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) mid_reset();
            op(1'($urandom_range(0, 99) < 85), c, 1'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 9) == 0));
        end
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
